// File: rtl/bit_pattern_assembler.sv
// Serial-to-parallel pattern assembler: collects WIDTH bits (one per handshake) into
// indexed positions, presents the word with valid/ready, flags EXPECT matches and counts them.
module bit_pattern_assembler #(
    parameter int               WIDTH     = 8,
    parameter bit               MSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0] EXPECT    = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_data,
    output logic             bit_ready,
    input  logic             flush,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic [WIDTH-1:0] pat_data,
    output logic             pat_match,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [WIDTH-1:0] MASK_TOP = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MASK_BOT = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] pat_data_q, pat_data_d;
    logic             pat_match_q, pat_match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_en_q;
    logic             take;
    logic [WIDTH-1:0] new_bits;
    logic [WIDTH-1:0] full_word;

    function automatic logic [WIDTH-1:0] pos_mask(input logic [IDX_W-1:0] idx);
        if (MSB_FIRST) return MASK_TOP >> idx;
        else           return MASK_BOT << idx;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // rdy_en_q keeps bit_ready low until the first edge after reset release
    assign bit_ready = rdy_en_q && ((state_q == ST_FILL) || pat_ready);
    assign pat_valid = (state_q == ST_HOLD);
    assign pat_data  = pat_data_q;
    assign pat_match = pat_match_q;
    assign match_cnt = cnt_q;

    assign take      = bit_valid && bit_ready;
    // idx_q is always 0 in HOLD, so the same mask serves the no-bubble first bit
    assign new_bits  = bit_data ? pos_mask(idx_q) : '0;
    assign full_word = word_q | new_bits;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        word_d      = word_q;
        pat_data_d  = pat_data_q;
        pat_match_d = pat_match_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_FILL: begin
                if (flush) begin
                    idx_d  = '0;
                    word_d = '0;
                end else if (take) begin
                    if (idx_q == IDX_LAST) begin
                        pat_data_d  = full_word;
                        pat_match_d = (full_word == EXPECT);
                        word_d      = '0;
                        idx_d       = '0;
                        state_d     = ST_HOLD;
                    end else begin
                        word_d = full_word;
                        idx_d  = idx_q + IDX_ONE;
                    end
                end
            end
            ST_HOLD: begin
                if (pat_ready) begin
                    if (pat_match_q) cnt_d = sat_inc(cnt_q);
                    state_d = ST_FILL;
                    if (take) begin
                        word_d = full_word;
                        idx_d  = IDX_ONE;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            idx_q       <= '0;
            word_q      <= '0;
            pat_data_q  <= '0;
            pat_match_q <= 1'b0;
            cnt_q       <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            pat_data_q  <= pat_data_d;
            pat_match_q <= pat_match_d;
            cnt_q       <= cnt_d;
            rdy_en_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bit_pattern_assembler.sv
// Directed bench: four assembler configurations share one stimulus stream; each phase
// checks the instance whose parameters it targets.
module tb_bit_pattern_assembler;

    logic clk = 1'b0;
    logic rst_n, bit_valid, bit_data, flush, pat_ready;

    logic        a_rdy, a_pv, a_pm;
    logic [1:0]  a_pd;
    logic [15:0] a_cnt;
    logic        b_rdy, b_pv, b_pm;
    logic [1:0]  b_pd;
    logic [15:0] b_cnt;
    logic        c_rdy, c_pv, c_pm;
    logic [7:0]  c_pd;
    logic [15:0] c_cnt;
    logic        d_rdy, d_pv, d_pm;
    logic [7:0]  d_pd;
    logic [1:0]  d_cnt;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] a5 = 8'hA5;
    logic [1:0] exp_d [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    always #5 clk = ~clk;

    bit_pattern_assembler #(.WIDTH(2), .MSB_FIRST(1'b1), .EXPECT(2'b10), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(a_rdy),
        .flush(flush), .pat_valid(a_pv), .pat_ready(pat_ready), .pat_data(a_pd),
        .pat_match(a_pm), .match_cnt(a_cnt));
    bit_pattern_assembler #(.WIDTH(2), .MSB_FIRST(1'b0), .EXPECT(2'b10), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(b_rdy),
        .flush(flush), .pat_valid(b_pv), .pat_ready(pat_ready), .pat_data(b_pd),
        .pat_match(b_pm), .match_cnt(b_cnt));
    bit_pattern_assembler #(.WIDTH(8), .MSB_FIRST(1'b1), .EXPECT(8'hA5), .CNT_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(c_rdy),
        .flush(flush), .pat_valid(c_pv), .pat_ready(pat_ready), .pat_data(c_pd),
        .pat_match(c_pm), .match_cnt(c_cnt));
    bit_pattern_assembler #(.WIDTH(8), .MSB_FIRST(1'b1), .EXPECT(8'h00), .CNT_W(2)) u_d (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(d_rdy),
        .flush(flush), .pat_valid(d_pv), .pat_ready(pat_ready), .pat_data(d_pd),
        .pat_match(d_pm), .match_cnt(d_cnt));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_data  = b;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bit_valid = 1'b0; bit_data = 1'b0; flush = 1'b0; pat_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; bit_valid = 1'b0; bit_data = 1'b0; flush = 1'b0; pat_ready = 1'b0;

        // reset state
        #3;
        chk("rst_bit_ready", 64'(c_rdy), 64'd0);
        chk("rst_pat_valid", 64'(c_pv), 64'd0);
        chk("rst_pat_data", 64'(c_pd), 64'd0);
        chk("rst_pat_match", 64'(c_pm), 64'd0);
        chk("rst_match_cnt", 64'(c_cnt), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rdy_before_edge", 64'(a_rdy), 64'd0);
        step();
        chk("rdy_after_edge", 64'(a_rdy), 64'd1);

        // WIDTH=2, MSB first vs LSB first, bits 1 then 0
        pat_ready = 1'b1;
        send_bit(1'b1);
        chk("w2_valid_after_1st", 64'(a_pv), 64'd0);
        send_bit(1'b0);
        bit_valid = 1'b0;
        chk("w2m_valid", 64'(a_pv), 64'd1);
        chk("w2m_data", 64'(a_pd), 64'h2);
        chk("w2m_match", 64'(a_pm), 64'd1);
        chk("w2m_cnt_pre", 64'(a_cnt), 64'd0);
        chk("w2l_data", 64'(b_pd), 64'h1);
        chk("w2l_match", 64'(b_pm), 64'd0);
        step();
        chk("w2m_cnt_post", 64'(a_cnt), 64'd1);
        chk("w2m_valid_post", 64'(a_pv), 64'd0);
        chk("w2l_cnt_post", 64'(b_cnt), 64'd0);

        // WIDTH=8 stall with pending bit, then no-bubble delivery
        do_reset();
        for (int i = 7; i >= 0; i--) send_bit(a5[i]);
        chk("stall_valid", 64'(c_pv), 64'd1);
        chk("stall_match", 64'(c_pm), 64'd1);
        bit_data = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rdy", 64'(c_rdy), 64'd0);
            chk("stall_data", 64'(c_pd), 64'hA5);
            step();
        end
        pat_ready = 1'b1;
        #1;
        chk("deliver_rdy", 64'(c_rdy), 64'd1);
        step();
        chk("deliver_cnt", 64'(c_cnt), 64'd1);
        chk("deliver_valid", 64'(c_pv), 64'd0);
        for (int i = 6; i >= 0; i--) begin
            send_bit(a5[i]);
            if (i == 1) chk("b2b_valid_early", 64'(c_pv), 64'd0);
        end
        bit_valid = 1'b0;
        chk("b2b_valid", 64'(c_pv), 64'd1);
        chk("b2b_data", 64'(c_pd), 64'hA5);
        step();
        chk("b2b_cnt", 64'(c_cnt), 64'd2);

        // flush mid-word drops the concurrent bit; flush in HOLD is ignored
        do_reset();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        flush = 1'b1;
        send_bit(1'b1);
        flush = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(a5[i]);
            if (i == 1) chk("flush_valid_early", 64'(c_pv), 64'd0);
        end
        bit_valid = 1'b0;
        chk("flush_valid", 64'(c_pv), 64'd1);
        chk("flush_data", 64'(c_pd), 64'hA5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("hold_flush_valid", 64'(c_pv), 64'd1);
        chk("hold_flush_data", 64'(c_pd), 64'hA5);

        // CNT_W=2 saturation on all-zero words
        do_reset();
        pat_ready = 1'b1;
        for (int w = 0; w < 5; w++) begin
            for (int i = 0; i < 8; i++) send_bit(1'b0);
            bit_valid = 1'b0;
            chk("sat_match", 64'(d_pm), 64'd1);
            step();
            chk($sformatf("sat_cnt_%0d", w), 64'(d_cnt), 64'(exp_d[w]));
        end

        // asynchronous reset while holding a word
        do_reset();
        pat_ready = 1'b1;
        for (int i = 7; i >= 0; i--) send_bit(a5[i]);
        bit_valid = 1'b0;
        step();
        pat_ready = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(a5[i]);
        bit_valid = 1'b0;
        chk("pre_arst_valid", 64'(c_pv), 64'd1);
        chk("pre_arst_cnt", 64'(c_cnt), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(c_pv), 64'd0);
        chk("arst_data", 64'(c_pd), 64'd0);
        chk("arst_cnt", 64'(c_cnt), 64'd0);
        chk("arst_rdy", 64'(c_rdy), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("arst_rdy_rel", 64'(c_rdy), 64'd0);
        step();
        chk("arst_rdy_edge", 64'(c_rdy), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bit_pattern_assembler.md
Name: bit_pattern_assembler

Overview:
- Serial-to-parallel counterpart of the pattern bit-select path: accepts one bit per handshake and writes each bit into its indexed position of a WIDTH-bit pattern word.
- When all WIDTH positions are filled, presents the word downstream with a valid/ready handshake.
- Flags whether the word equals a parameterised expected pattern and keeps a saturating count of matches.
- Sits between a serial bit source and any consumer that bit-selects from the assembled pattern.

Parameters:
- WIDTH, 8, pattern width in bits; legal range 2..64.
- MSB_FIRST, 1, 1: first accepted bit lands in bit WIDTH-1 and fill proceeds downward; 0: first bit lands in bit 0 and fill proceeds upward.
- EXPECT, {WIDTH{1'b0}}, reference pattern for the match flag.
- CNT_W, 16, width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- bit_valid  input  1  source offers bit_data.
- bit_data  input  1  serial bit.
- bit_ready  output  1  assembler accepts bit_data this cycle.
- flush  input  1  synchronous discard of a partial word.
- pat_valid  output  1  pat_data holds a complete word.
- pat_ready  input  1  consumer takes the word.
- pat_data  output  WIDTH  assembled pattern.
- pat_match  output  1  pat_data == EXPECT; meaningful only while pat_valid=1.
- match_cnt  output  CNT_W  number of delivered words that matched, saturating.

Behaviour:
- Reset (rst_n=0, async):
  - state=FILL, idx=0, shift register=0.
  - pat_valid=0, pat_data=0, pat_match=0, match_cnt=0.
  - bit_ready=0 while rst_n=0; bit_ready=1 from the first clk edge after deassertion.
- Bit acceptance: a bit is taken on a clk edge with bit_valid && bit_ready.
- State FILL:
  - bit_ready=1, pat_valid=0.
  - Each accepted bit is written to position p: p = WIDTH-1-idx if MSB_FIRST, else p = idx. Then idx increments.
  - Accepting the bit at idx=WIDTH-1 completes the word: same edge loads pat_data, computes pat_match from the completed word, sets idx=0, and moves to HOLD.
  - Latency: pat_valid rises on the edge that accepts the last bit, i.e. visible the cycle after that bit's handshake.
  - Unwritten positions of a word in progress read as 0; the internal register clears when a word completes.
- State HOLD:
  - pat_valid=1.
  - pat_data and pat_match stay stable until the handshake completes; no change while pat_ready=0.
  - bit_ready = pat_ready, so there is no bubble: on an edge with pat_valid && pat_ready && bit_valid, the word is delivered and the new bit becomes position 0 of the next word (idx becomes 1).
  - On delivery (pat_valid && pat_ready): if pat_match=1, match_cnt increments, holding at 2^CNT_W-1 once saturated. Then return to FILL, unless WIDTH bits were already re-collected, which is impossible since at most one bit is accepted per cycle.
- flush:
  - In FILL: idx=0 and the partial word is cleared; a bit handshaking in the same cycle is dropped. bit_ready stays 1, so the source sees it as accepted and discarded.
  - In HOLD: flush is ignored; a completed word is never discarded.
- Throughput: one word per WIDTH cycles with continuous bit_valid and pat_ready=1.
- match_cnt is never cleared except by reset.
- Reset asserted mid-word or mid-HOLD: everything returns to reset values immediately; the partial or pending word is lost.

Test Plan:
- WIDTH=2, MSB_FIRST=1, EXPECT=2'b10, pat_ready=1; send bits 1 then 0 -> pat_valid=1 one cycle after the 2nd bit, pat_data=2'b10, pat_match=1, match_cnt goes 0->1 on delivery.
- Same config, MSB_FIRST=0; send 1 then 0 -> pat_data=2'b01, pat_match=0, match_cnt stays 0.
- WIDTH=8, pat_ready=0 after a word completes; keep bit_valid=1 -> bit_ready=0, pat_data stable for 5 cycles; raise pat_ready -> the pending bit is accepted on the delivery edge (back-to-back, no bubble); next word completes after 7 more bits.
- WIDTH=8, after 3 bits assert flush with bit_valid=1 -> idx=0, that bit is dropped; 8 fresh bits 0xA5 (MSB first) -> pat_data=8'hA5.
- CNT_W=2, EXPECT=0, deliver five all-zero words -> match_cnt reads 1,2,3,3,3.
- Deassert rst_n asynchronously mid-HOLD -> pat_valid=0, pat_data=0, match_cnt=0 immediately (no clk edge needed); bit_ready=1 after the first clk edge post-release.
